// File: rtl/wb_trace_pkg.sv
// rtl/wb_trace_pkg.sv - shared state encoding and trace entry layout for the writeback trace buffer
package wb_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } trace_state_t;

    localparam int XLEN_DEF = 64;
    localparam int CYCW_DEF = 32;
    localparam int INSTR_W  = 32;
    localparam int RD_W     = 5;

    // Entry layout, most significant first: cycle, pc, instr, rd, data.
    function automatic int entry_width(input int xlen, input int cycw);
        return cycw + xlen + INSTR_W + RD_W + xlen;
    endfunction

    localparam int ENTRY_W = entry_width(XLEN_DEF, CYCW_DEF);

    typedef struct packed {
        logic [CYCW_DEF-1:0] cycle;
        logic [XLEN_DEF-1:0] pc;
        logic [INSTR_W-1:0]  instr;
        logic [RD_W-1:0]     rd;
        logic [XLEN_DEF-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/wb_trace_buffer_if.sv
// rtl/wb_trace_buffer_if.sv - writeback tap stream and readout handshake bundle
interface wb_trace_buffer_if #(
    parameter int XLEN = 64,
    parameter int CYCW = 32
);
    import wb_trace_pkg::*;

    logic               wb_valid;
    logic [XLEN-1:0]    wb_pc;
    logic [INSTR_W-1:0] wb_instr;
    logic [RD_W-1:0]    wb_rd;
    logic [XLEN-1:0]    wb_data;

    logic               rd_ready;
    logic               rd_valid;
    logic [CYCW-1:0]    rd_cycle;
    logic [XLEN-1:0]    rd_pc;
    logic [INSTR_W-1:0] rd_instr;
    logic [RD_W-1:0]    rd_rd;
    logic [XLEN-1:0]    rd_data;

    modport master (
        output wb_valid, wb_pc, wb_instr, wb_rd, wb_data, rd_ready,
        input  rd_valid, rd_cycle, rd_pc, rd_instr, rd_rd, rd_data
    );

    modport slave (
        input  wb_valid, wb_pc, wb_instr, wb_rd, wb_data, rd_ready,
        output rd_valid, rd_cycle, rd_pc, rd_instr, rd_rd, rd_data
    );
endinterface

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - entry storage with synchronous write and asynchronous read
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are abandoned on reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - triggered circular trace of retiring instructions with oldest-first readout
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int DEPTH     = 16,
    parameter int CYCW      = 32,
    parameter int POST_TRIG = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   force_trig,
    input  logic                   trig_en,
    input  logic [XLEN-1:0]        trig_pc,
    wb_trace_buffer_if.slave       bus,
    output logic [1:0]             state,
    output logic [$clog2(DEPTH):0] count,
    output logic [CYCW-1:0]        cycle_cnt,
    output logic [CYCW-1:0]        retired_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = entry_width(XLEN, CYCW);
    localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);

    trace_state_t  st, st_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] post_cnt;
    logic [AW:0]   cnt;
    logic          trig_hit;
    logic          capture;
    logic          rd_valid;
    logic          pop;
    logic [EW-1:0] entry_in;
    logic [EW-1:0] entry_out;

    assign trig_hit = force_trig || (trig_en && bus.wb_valid && (bus.wb_pc == trig_pc));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            st <= ST_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // Next-state: arm, trigger, post-window expiry, drain to empty.
    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:   if (arm) st_nxt = ST_ARMED;
            ST_ARMED:  if (trig_hit) st_nxt = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
            ST_POST:   if (capture && post_cnt == AW'(1)) st_nxt = ST_FROZEN;
            ST_FROZEN: if (cnt == '0 || (pop && cnt == (AW+1)'(1))) st_nxt = ST_IDLE;
            default:   st_nxt = ST_IDLE;
        endcase
    end

    // Outputs of the FSM: capture enable, readout valid and the pop strobe.
    always_comb begin
        capture  = bus.wb_valid && (st == ST_ARMED || st == ST_POST);
        rd_valid = (st == ST_FROZEN) && (cnt != '0);
        pop      = rd_valid && bus.rd_ready;
    end

    // Write pointer, occupancy and post-trigger countdown.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            cnt      <= '0;
            post_cnt <= '0;
        end else begin
            if (st == ST_IDLE && arm) begin
                wr_ptr <= '0;
                cnt    <= '0;
            end
            if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (cnt != FULL) cnt <= cnt + 1'b1;
            end
            if (pop) begin
                cnt <= cnt - 1'b1;
            end
            if (st == ST_ARMED && trig_hit) begin
                post_cnt <= POST_INIT;
            end else if (st == ST_POST && capture) begin
                post_cnt <= post_cnt - 1'b1;
            end
        end
    end

    // Free-running cycle stamp and retire counter, both wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (bus.wb_valid) retired_cnt <= retired_cnt + 1'b1;
        end
    end

    // The write pointer is frozen while reading, and each pop moves the read
    // pointer up by one as the count drops by one, so the oldest entry is
    // always wr_ptr - cnt. A full buffer (cnt == DEPTH) reads from wr_ptr.
    assign rd_ptr = wr_ptr - cnt[AW-1:0];

    assign entry_in = {cycle_cnt, bus.wb_pc, bus.wb_instr, bus.wb_rd, bus.wb_data};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .we    (capture),
        .waddr (wr_ptr),
        .wdata (entry_in),
        .raddr (rd_ptr),
        .rdata (entry_out)
    );

    assign bus.rd_valid = rd_valid;
    assign {bus.rd_cycle, bus.rd_pc, bus.rd_instr, bus.rd_rd, bus.rd_data} = entry_out;
    assign state = st;
    assign count = cnt;
endmodule
